// File: rtl/pipe_reg_fd_ctl.sv
// Fetch-to-decode pipeline register with stall/bubble control, a valid flag,
// saturating stall/bubble cycle counters and a sticky stall+bubble conflict flag.
module pipe_reg_fd_ctl #(
  parameter int                WORD_W      = 64,
  parameter int                STAT_W      = 3,
  parameter int                CNT_W       = 16,
  parameter logic [3:0]        NOP_ICODE   = 4'h1,
  parameter logic [3:0]        RNONE       = 4'hF,
  parameter logic [STAT_W-1:0] BUBBLE_STAT = STAT_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAT_W-1:0] f_stat,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [3:0]        f_rA,
  input  logic [3:0]        f_rB,
  input  logic [WORD_W-1:0] f_valC,
  input  logic [WORD_W-1:0] f_valP,
  input  logic              D_stall,
  input  logic              D_bubble,
  output logic [STAT_W-1:0] D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [WORD_W-1:0] D_valC,
  output logic [WORD_W-1:0] D_valP,
  output logic              D_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              ctl_err
);

  localparam int N_CNT   = 2;
  localparam int CNT_STL = 0;
  localparam int CNT_BUB = 1;

  logic [STAT_W-1:0] stat_q,  stat_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ifun_q,  ifun_d;
  logic [3:0]        ra_q,    ra_d;
  logic [3:0]        rb_q,    rb_d;
  logic [WORD_W-1:0] valc_q,  valc_d;
  logic [WORD_W-1:0] valp_q,  valp_d;
  logic              valid_q, valid_d;
  logic              err_q,   err_d;

  logic [N_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CNT-1:0]            cnt_inc;
  logic [N_CNT-1:0]            cnt_sat;

  // A simultaneous bubble is dropped while stalled, so it is not counted either.
  assign cnt_inc[CNT_STL] = D_stall;
  assign cnt_inc[CNT_BUB] = D_bubble & ~D_stall;

  generate
    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
      assign cnt_sat[gi] = &cnt_q[gi];
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (cnt_inc[gi] && !cnt_sat[gi]) begin
          cnt_d[gi] = cnt_q[gi] + 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    valid_d = valid_q;
    err_d   = err_q | (D_stall & D_bubble);
    if (!D_stall) begin
      if (D_bubble) begin
        stat_d  = BUBBLE_STAT;
        icode_d = NOP_ICODE;
        ifun_d  = 4'h0;
        ra_d    = RNONE;
        rb_d    = RNONE;
        valc_d  = '0;
        valp_d  = '0;
        valid_d = 1'b0;
      end else begin
        stat_d  = f_stat;
        icode_d = f_icode;
        ifun_d  = f_ifun;
        ra_d    = f_rA;
        rb_d    = f_rB;
        valc_d  = f_valC;
        valp_d  = f_valP;
        valid_d = 1'b1;
      end
    end
  end

  // Reset loads the same NOP bubble that D_bubble injects.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q  <= BUBBLE_STAT;
      icode_q <= NOP_ICODE;
      ifun_q  <= 4'h0;
      ra_q    <= RNONE;
      rb_q    <= RNONE;
      valc_q  <= '0;
      valp_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign D_stat     = stat_q;
  assign D_icode    = icode_q;
  assign D_ifun     = ifun_q;
  assign D_rA       = ra_q;
  assign D_rB       = rb_q;
  assign D_valC     = valc_q;
  assign D_valP     = valp_q;
  assign D_valid    = valid_q;
  assign stall_cnt  = cnt_q[CNT_STL];
  assign bubble_cnt = cnt_q[CNT_BUB];
  assign ctl_err    = err_q;

endmodule

// File: tb/tb_pipe_reg_fd_ctl.sv
// Directed bench for pipe_reg_fd_ctl: the driver queues hand-computed expectations,
// a monitor pops one after each rising edge and compares against the DUT outputs.
module tb_pipe_reg_fd_ctl;

  localparam int WORD_W = 64;
  localparam int STAT_W = 3;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [STAT_W-1:0] stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [WORD_W-1:0] valc;
    logic [WORD_W-1:0] valp;
  } fld_t;

  typedef struct packed {
    fld_t             d;
    logic             valid;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] bcnt;
    logic             err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [STAT_W-1:0] f_stat;
  logic [3:0]        f_icode, f_ifun, f_rA, f_rB;
  logic [WORD_W-1:0] f_valC, f_valP;
  logic              D_stall, D_bubble;
  logic [STAT_W-1:0] D_stat;
  logic [3:0]        D_icode, D_ifun, D_rA, D_rB;
  logic [WORD_W-1:0] D_valC, D_valP;
  logic              D_valid;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
  logic              ctl_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   txn      = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_reg_fd_ctl #(
    .WORD_W(WORD_W), .STAT_W(STAT_W), .CNT_W(CNT_W),
    .NOP_ICODE(4'h1), .RNONE(4'hF), .BUBBLE_STAT(3'd1)
  ) dut (
    .clk(clk), .rst(rst),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .D_stall(D_stall), .D_bubble(D_bubble),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_valid(D_valid),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .ctl_err(ctl_err)
  );

  // Hand-written field vectors.
  localparam fld_t NOP = '{stat:3'd1, icode:4'h1, ifun:4'h0, ra:4'hF, rb:4'hF, valc:64'h0, valp:64'h0};
  localparam fld_t FA  = '{stat:3'd1, icode:4'h3, ifun:4'h0, ra:4'h5, rb:4'h2,
                           valc:64'h1234_5678_9ABC_DEF0, valp:64'h10};
  localparam fld_t FB  = '{stat:3'd4, icode:4'h2, ifun:4'h1, ra:4'h7, rb:4'h8,
                           valc:64'hFFFF_0000_AAAA_5555, valp:64'h20};
  localparam fld_t FC  = '{stat:3'd2, icode:4'h5, ifun:4'h3, ra:4'h1, rb:4'h9,
                           valc:64'h8000_0000_0000_0001, valp:64'h2A};
  localparam fld_t FD  = '{stat:3'd7, icode:4'hB, ifun:4'hE, ra:4'hC, rb:4'hD,
                           valc:64'hDEAD_BEEF_CAFE_F00D, valp:64'hFFFF_FFFF_FFFF_FFF0};
  localparam fld_t FE  = '{stat:3'd3, icode:4'h7, ifun:4'h6, ra:4'h0, rb:4'h4,
                           valc:64'h0000_0000_0000_00FF, valp:64'h33};
  localparam fld_t FG  = '{stat:3'd1, icode:4'h6, ifun:4'h2, ra:4'h3, rb:4'hA,
                           valc:64'h0F0F_0F0F_0F0F_0F0F, valp:64'h44};

  function automatic exp_t mk(fld_t d, logic v, int s, int b, logic e);
    exp_t x;
    x.d     = d;
    x.valid = v;
    x.scnt  = CNT_W'(s);
    x.bcnt  = CNT_W'(b);
    x.err   = e;
    return x;
  endfunction

  // Drive one cycle on the falling edge and queue the state expected after the next rising edge.
  task automatic cyc(input logic r, input logic st, input logic bu, input fld_t f, input exp_t e);
    @(negedge clk);
    rst      = r;
    D_stall  = st;
    D_bubble = bu;
    f_stat   = f.stat;
    f_icode  = f.icode;
    f_ifun   = f.ifun;
    f_rA     = f.ra;
    f_rB     = f.rb;
    f_valC   = f.valc;
    f_valP   = f.valp;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL txn %0d %s: got 0x%0h, expected 0x%0h", txn, name, act, req);
    end
  endtask

  // Monitor: the register presents a new value every cycle, so check once per queued transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        chk("D_stat",  WORD_W'(D_stat),  WORD_W'(e.d.stat));
        chk("D_icode", WORD_W'(D_icode), WORD_W'(e.d.icode));
        chk("D_ifun",  WORD_W'(D_ifun),  WORD_W'(e.d.ifun));
        chk("D_rA",    WORD_W'(D_rA),    WORD_W'(e.d.ra));
        chk("D_rB",    WORD_W'(D_rB),    WORD_W'(e.d.rb));
        chk("D_valC",  D_valC,           e.d.valc);
        chk("D_valP",  D_valP,           e.d.valp);
        chk("D_valid", WORD_W'(D_valid), WORD_W'(e.valid));
        chk("stall_cnt",  WORD_W'(stall_cnt),  WORD_W'(e.scnt));
        chk("bubble_cnt", WORD_W'(bubble_cnt), WORD_W'(e.bcnt));
        chk("ctl_err",    WORD_W'(ctl_err),    WORD_W'(e.err));
        $display("txn %0d: icode=%0h stat=%0d valid=%0b stall_cnt=%0d bubble_cnt=%0d ctl_err=%0b",
                 txn, D_icode, D_stat, D_valid, stall_cnt, bubble_cnt, ctl_err);
      end
    end
  end

  initial begin
    int wait_cyc;
    rst = 1'b1; D_stall = 1'b0; D_bubble = 1'b0;
    f_stat = '0; f_icode = '0; f_ifun = '0; f_rA = '0; f_rB = '0; f_valC = '0; f_valP = '0;

    // Reset with junk on the fetch side.
    cyc(1, 0, 0, FD, mk(NOP, 0, 0, 0, 0));
    cyc(1, 1, 1, FC, mk(NOP, 0, 0, 0, 0));
    // Normal flow, including full 3-bit stat.
    cyc(0, 0, 0, FA, mk(FA, 1, 0, 0, 0));
    cyc(0, 0, 0, FB, mk(FB, 1, 0, 0, 0));
    // Stall 3 cycles while fetch changes.
    cyc(0, 1, 0, FC, mk(FB, 1, 1, 0, 0));
    cyc(0, 1, 0, FD, mk(FB, 1, 2, 0, 0));
    cyc(0, 1, 0, FE, mk(FB, 1, 3, 0, 0));
    cyc(0, 0, 0, FC, mk(FC, 1, 3, 0, 0));
    // Bubble, then the same fetch word loads.
    cyc(0, 0, 1, FG, mk(NOP, 0, 3, 1, 0));
    cyc(0, 0, 0, FG, mk(FG,  1, 3, 1, 0));
    // Conflict: held, stall counted, bubble ignored, error latched.
    cyc(0, 1, 1, FA, mk(FG,  1, 4, 1, 1));
    cyc(0, 0, 0, FA, mk(FA,  1, 4, 1, 1));
    // Stall while holding a bubble keeps the bubble.
    cyc(0, 0, 1, FB, mk(NOP, 0, 4, 2, 1));
    cyc(0, 1, 0, FB, mk(NOP, 0, 5, 2, 1));
    // Reset in the middle of a stall/bubble sequence.
    cyc(1, 1, 1, FB, mk(NOP, 0, 0, 0, 0));
    // Saturation: 20 stall cycles on a 4-bit counter.
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 1, 0, FE, mk(NOP, 0, (i > 15) ? 15 : i, 0, 0));
    end
    cyc(0, 0, 0, FD, mk(FD, 1, 15, 0, 0));
    cyc(1, 1, 0, FA, mk(NOP, 0, 0, 0, 0));
    // Bubble saturation, then reset mid-bubble.
    for (int i = 1; i <= 17; i++) begin
      cyc(0, 0, 1, FA, mk(NOP, 0, 0, (i > 15) ? 15 : i, 0));
    end
    cyc(1, 0, 1, FA, mk(NOP, 0, 0, 0, 0));
    cyc(0, 0, 0, FE, mk(FE,  1, 0, 0, 0));

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d transactions unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
